// File: rtl/block_transfer_sequencer_pkg.sv
// Shared definitions for the LDM/STM block-transfer sequencer: FSM encoding,
// addressing-mode codes and the register-list population count.
package block_transfer_sequencer_pkg;

    localparam int REG_LIST_W         = 16;
    localparam int COUNT_W            = 5;
    localparam int DEFAULT_WORD_BYTES = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_XFER  = 3'd2,
        ST_WB    = 3'd3,
        ST_DONE  = 3'd4
    } bts_state_t;

    // Mode code is {up, pre}
    localparam logic [1:0] MODE_DA = 2'b00;
    localparam logic [1:0] MODE_DB = 2'b01;
    localparam logic [1:0] MODE_IA = 2'b10;
    localparam logic [1:0] MODE_IB = 2'b11;

    function automatic logic [COUNT_W-1:0] popcount(input logic [REG_LIST_W-1:0] v);
        logic [COUNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < REG_LIST_W; i++) begin
            cnt = cnt + COUNT_W'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/block_transfer_sequencer_lowest_set_bit.sv
// Priority encoder: index of the lowest set bit of a register list, plus a
// flag that at least one bit is set.
module lowest_set_bit
    import block_transfer_sequencer_pkg::*;
#(
    parameter int WIDTH = REG_LIST_W,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] index,
    output logic             valid
);

    always_comb begin
        index = '0;
        valid = |vec;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/block_transfer_sequencer.sv
// LDM/STM sequencer: walks a register list lowest-first, issuing one memory
// request per register, then optionally writes the final address to the base.
module block_transfer_sequencer
    import block_transfer_sequencer_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int NREGS      = 16,
    parameter int WORD_BYTES = DEFAULT_WORD_BYTES
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    output logic                     ready,
    input  logic                     load,
    input  logic                     up,
    input  logic                     pre,
    input  logic                     writeback,
    input  logic [$clog2(NREGS)-1:0] base_reg,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic [NREGS-1:0]         reg_list,
    output logic [$clog2(NREGS)-1:0] rf_read_num,
    input  logic [ADDR_W-1:0]        rf_read_data,
    output logic                     rf_write_en,
    output logic [$clog2(NREGS)-1:0] rf_write_num,
    output logic [ADDR_W-1:0]        rf_write_data,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [ADDR_W-1:0]        mem_wdata,
    input  logic                     mem_ack,
    input  logic [ADDR_W-1:0]        mem_rdata,
    output logic                     done
);

    localparam int IDX_W = $clog2(NREGS);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(WORD_BYTES);

    bts_state_t state_q, state_d;

    logic              cmd_load_q;
    logic              cmd_up_q;
    logic              cmd_pre_q;
    logic              cmd_wb_q;
    logic [IDX_W-1:0]  cmd_base_reg_q;
    logic [ADDR_W-1:0] cmd_base_addr_q;
    logic [NREGS-1:0]  cmd_list_q;
    logic [NREGS-1:0]  remain_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] final_q;
    logic              gap_q;

    logic [IDX_W-1:0]   cur_idx;
    logic               cur_valid;
    logic [NREGS-1:0]   cur_onehot;
    logic [NREGS-1:0]   remain_after;
    logic [COUNT_W-1:0] list_count;
    logic [ADDR_W-1:0]  span;
    logic [ADDR_W-1:0]  first_addr;
    logic [ADDR_W-1:0]  last_addr;
    logic               wb_taken;
    logic               xfer_ack;

    function automatic logic [ADDR_W-1:0] start_address(
        input logic [1:0]        mode,
        input logic [ADDR_W-1:0] base,
        input logic [ADDR_W-1:0] total
    );
        logic [ADDR_W-1:0] a;
        case (mode)
            MODE_IA: a = base;
            MODE_IB: a = base + STEP;
            MODE_DA: a = base - total + STEP;
            MODE_DB: a = base - total;
            default: a = base;
        endcase
        return a;
    endfunction

    lowest_set_bit #(
        .WIDTH (NREGS),
        .IDX_W (IDX_W)
    ) u_lowest_set_bit (
        .vec   (remain_q),
        .index (cur_idx),
        .valid (cur_valid)
    );

    assign cur_onehot   = {{(NREGS-1){1'b0}}, 1'b1} << cur_idx;
    assign remain_after = remain_q & ~cur_onehot;
    assign list_count   = popcount(cmd_list_q);
    assign span         = ADDR_W'(list_count) * STEP;
    assign first_addr   = start_address({cmd_up_q, cmd_pre_q}, cmd_base_addr_q, span);
    assign last_addr    = cmd_up_q ? (cmd_base_addr_q + span) : (cmd_base_addr_q - span);
    // A loaded base register keeps the value read from memory.
    assign wb_taken     = cmd_wb_q && !(cmd_load_q && cmd_list_q[cmd_base_reg_q]);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        ready         = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        rf_read_num   = '0;
        rf_write_en   = 1'b0;
        rf_write_num  = '0;
        rf_write_data = '0;
        done          = 1'b0;
        xfer_ack      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = (list_count == '0) ? ST_DONE : ST_XFER;
            end
            ST_XFER: begin
                // Request is idle for one cycle after each ack.
                if (!gap_q && cur_valid) begin
                    mem_req  = 1'b1;
                    mem_we   = !cmd_load_q;
                    mem_addr = addr_q;
                    if (!cmd_load_q) begin
                        rf_read_num = cur_idx;
                        mem_wdata   = rf_read_data;
                    end
                    if (mem_ack) begin
                        xfer_ack = 1'b1;
                        if (cmd_load_q) begin
                            rf_write_en   = 1'b1;
                            rf_write_num  = cur_idx;
                            rf_write_data = mem_rdata;
                        end
                        if (remain_after == '0) begin
                            state_d = wb_taken ? ST_WB : ST_DONE;
                        end
                    end
                end
            end
            ST_WB: begin
                rf_write_en   = 1'b1;
                rf_write_num  = cmd_base_reg_q;
                rf_write_data = final_q;
                state_d       = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cmd_load_q      <= 1'b0;
            cmd_up_q        <= 1'b0;
            cmd_pre_q       <= 1'b0;
            cmd_wb_q        <= 1'b0;
            cmd_base_reg_q  <= '0;
            cmd_base_addr_q <= '0;
            cmd_list_q      <= '0;
            remain_q        <= '0;
            addr_q          <= '0;
            final_q         <= '0;
            gap_q           <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && start) begin
                cmd_load_q      <= load;
                cmd_up_q        <= up;
                cmd_pre_q       <= pre;
                cmd_wb_q        <= writeback;
                cmd_base_reg_q  <= base_reg;
                cmd_base_addr_q <= base_addr;
                cmd_list_q      <= reg_list;
                remain_q        <= reg_list;
                gap_q           <= 1'b0;
            end
            if (state_q == ST_SETUP) begin
                addr_q  <= first_addr;
                final_q <= last_addr;
            end
            if (state_q == ST_XFER) begin
                if (gap_q) begin
                    gap_q <= 1'b0;
                end else if (xfer_ack) begin
                    remain_q <= remain_after;
                    addr_q   <= addr_q + STEP;
                    gap_q    <= (remain_after != '0);
                end
            end
        end
    end

endmodule
